// File: rtl/huffman_encoder.sv
// Serial Huffman-style encoder: unary codes for small symbols, escape prefix plus raw
// symbol otherwise. Codewords leave MSB first on a valid/ready bit stream.
module huffman_encoder #(
    parameter int SYM_W     = 5,
    parameter int UNARY_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] symbol_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             busy
);

    localparam int CODE_W = UNARY_MAX + SYM_W;
    localparam int CNT_W  = $clog2(CODE_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                last_s;
    logic                accept_s;
    logic                xfer_s;

    // Codeword left-aligned in the shift register so bit_out is always the register MSB.
    function automatic logic [CODE_W-1:0] code_of(input logic [SYM_W-1:0] sym);
        int                k;
        logic [CODE_W-1:0] code;
        k    = int'(sym);
        code = {CODE_W{1'b0}};
        if (k >= 1 && k <= UNARY_MAX) begin
            for (int i = 0; i < CODE_W; i++) begin
                code[CODE_W-1-i] = (i < k - 1);
            end
        end else begin
            code = {{UNARY_MAX{1'b1}}, sym};
        end
        return code;
    endfunction

    function automatic logic [CNT_W-1:0] len_of(input logic [SYM_W-1:0] sym);
        int k;
        k = int'(sym);
        if (k >= 1 && k <= UNARY_MAX) begin
            return CNT_W'(k);
        end else begin
            return CNT_W'(CODE_W);
        end
    endfunction

    // run_q keeps sym_ready low until the first edge after reset release.
    assign last_s    = (cnt_q == CNT_W'(1));
    assign bit_valid = (state_q == SHIFT);
    assign busy      = bit_valid;
    assign bit_out   = sr_q[CODE_W-1];
    assign sym_ready = run_q && ((state_q == IDLE) || (last_s && bit_ready));
    assign accept_s  = sym_valid && sym_ready;
    assign xfer_s    = bit_valid && bit_ready;

    // Next-state logic: load on acceptance, shift on transfer, hold while stalled.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        run_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SHIFT;
                    sr_d    = code_of(symbol_in);
                    cnt_d   = len_of(symbol_in);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s && last_s) begin
                    if (accept_s) begin
                        sr_d  = code_of(symbol_in);
                        cnt_d = len_of(symbol_in);
                    end else begin
                        state_d = IDLE;
                        sr_d    = {CODE_W{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else if (xfer_s) begin
                    sr_d  = {sr_q[CODE_W-2:0], 1'b0};
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    sr_d = sr_q;
                end
            end
            default: begin
                state_d = IDLE;
                sr_d    = {CODE_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register; asynchronous reset drops any codeword in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= {CODE_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: directed scenarios plus randomized traffic,
// all checked against a queue-of-bits reference model built from the code table rules.
module tb_huffman_encoder;

    localparam int SYM_W = 5;
    localparam int UM    = 7;

    logic             clk;
    logic             rst;
    logic [SYM_W-1:0] symbol_in;
    logic             sym_valid;
    logic             sym_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic             busy;

    int n_checks;
    int n_fail;
    bit model[$];
    bit cap[$];

    huffman_encoder #(.SYM_W(SYM_W), .UNARY_MAX(UM)) dut (
        .clk       (clk),
        .rst       (rst),
        .symbol_in (symbol_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bit sequence for one symbol, straight from the code table.
    function automatic void push_code(input int s);
        if (s >= 1 && s <= UM) begin
            for (int i = 0; i < s - 1; i++) model.push_back(1'b1);
            model.push_back(1'b0);
        end else begin
            for (int i = 0; i < UM; i++) model.push_back(1'b1);
            for (int i = SYM_W - 1; i >= 0; i--) model.push_back(1'(s >> i));
        end
    endfunction

    // One clock cycle: drive, check at negedge, advance the model, step past posedge.
    task automatic step(input logic v, input logic [SYM_W-1:0] s, input logic br, output logic acc);
        logic exp_valid;
        logic exp_ready;
        sym_valid = v;
        symbol_in = s;
        bit_ready = br;
        @(negedge clk);
        exp_valid = (model.size() != 0);
        exp_ready = !exp_valid || (model.size() == 1 && br);
        check_eq("bit_valid", 32'(bit_valid), 32'(exp_valid));
        check_eq("busy", 32'(busy), 32'(exp_valid));
        check_eq("sym_ready", 32'(sym_ready), 32'(exp_ready));
        check_eq("bit_out", 32'(bit_out), exp_valid ? 32'(model[0]) : 32'd0);
        if (exp_valid && br) begin
            cap.push_back(bit_out);
            void'(model.pop_front());
        end
        acc = v && exp_ready;
        if (acc) push_code(int'(s));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b1, a);
    endtask

    // Flush the model, take one idle cycle, then compare the captured stream to a constant.
    task automatic finish_scn(input string tag, input int len, input logic [31:0] exp);
        logic [31:0] packed_v;
        logic        a;
        for (int i = 0; i < 40 && model.size() != 0; i++) step(1'b0, 5'd0, 1'b1, a);
        check_eq({tag, "_drained"}, 32'(model.size()), 32'd0);
        step(1'b0, 5'd0, 1'b1, a);
        packed_v = 32'd0;
        foreach (cap[i]) packed_v = (packed_v << 1) | 32'(cap[i]);
        check_eq({tag, "_len"}, 32'(cap.size()), 32'(len));
        check_eq({tag, "_bits"}, packed_v, exp);
        cap.delete();
    endtask

    initial begin
        logic a;
        logic pend;
        logic [SYM_W-1:0] ps;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        sym_valid = 1'b0;
        symbol_in = 5'd0;
        bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_bit_valid", 32'(bit_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_bit_out", 32'(bit_out), 32'd0);
        check_eq("rst_sym_ready", 32'(sym_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", 32'(sym_ready), 32'd1);

        step(1'b1, 5'd1, 1'b1, a);
        finish_scn("sym1", 1, 32'b0);

        step(1'b1, 5'd3, 1'b1, a);
        finish_scn("sym3", 3, 32'b110);

        step(1'b1, 5'd20, 1'b1, a);
        finish_scn("sym20", 12, 32'b1111111_10100);

        step(1'b1, 5'd0, 1'b1, a);
        finish_scn("sym0", 12, 32'b1111111_00000);

        step(1'b1, 5'd2, 1'b1, a);
        step(1'b1, 5'd1, 1'b1, a);
        check_eq("b2b_not_yet", 32'(a), 32'd0);
        step(1'b1, 5'd1, 1'b1, a);
        check_eq("b2b_accept", 32'(a), 32'd1);
        finish_scn("b2b", 3, 32'b100);

        step(1'b1, 5'd4, 1'b1, a);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b0, a);
        finish_scn("stall", 4, 32'b1110);

        // Reset asserted while the 5th bit of symbol 9 is on the line.
        step(1'b1, 5'd9, 1'b1, a);
        idle(4);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_bit_valid", 32'(bit_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_bit_out", 32'(bit_out), 32'd0);
        check_eq("mid_rst_sym_ready", 32'(sym_ready), 32'd0);
        model.delete();
        cap.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_mid_rst", 32'(sym_ready), 32'd1);
        step(1'b1, 5'd2, 1'b1, a);
        finish_scn("post_rst", 2, 32'b10);

        // Random traffic; a presented symbol is held until accepted.
        pend = 1'b0;
        ps   = 5'd0;
        for (int c = 0; c < 800; c++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                ps   = SYM_W'($urandom_range(0, 31));
            end
            step(pend, pend ? ps : SYM_W'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), a);
            if (a) pend = 1'b0;
        end
        for (int i = 0; i < 40 && model.size() != 0; i++) step(1'b0, 5'd0, 1'b1, a);
        check_eq("rand_drained", 32'(model.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_encoder.md
HUFFMAN_ENCODER -- requirements
Module: huffman_encoder

Interface
REQ-001 The block SHALL have parameter SYM_W, default 5, symbol width in bits.
REQ-002 The block SHALL have parameter UNARY_MAX, default 7, highest symbol value that uses a unary codeword.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port symbol_in, input, SYM_W, symbol to encode.
REQ-006 The block SHALL have port sym_valid, input, 1, symbol_in holds a symbol.
REQ-007 The block SHALL have port sym_ready, output, 1, encoder accepts symbol_in this cycle.
REQ-008 The block SHALL have port bit_out, output, 1, serial code bit, MSB first, feeds the decoder bit_in.
REQ-009 The block SHALL have port bit_valid, output, 1, bit_out holds a code bit.
REQ-010 The block SHALL have port bit_ready, input, 1, downstream consumes bit_out this cycle.
REQ-011 The block SHALL have port busy, output, 1, a codeword is in flight.

Function
REQ-012 Symbol acceptance SHALL occur at a rising edge where sym_valid and sym_ready are both 1; a bit transfer SHALL occur at a rising edge where bit_valid and bit_ready are both 1.
REQ-013 Code table: symbol k with 1 <= k <= UNARY_MAX SHALL be (k-1) ones followed by one zero, length k.
REQ-014 Code table: symbol 0 and symbols k > UNARY_MAX SHALL be UNARY_MAX ones followed by symbol_in[SYM_W-1:0] MSB first, length UNARY_MAX+SYM_W (12 at defaults).
REQ-015 The block SHALL latch the codeword into a shift register and a length counter wide enough for UNARY_MAX+SYM_W on acceptance.
REQ-016 The FSM SHALL have states IDLE and SHIFT.
REQ-017 IDLE -> SHIFT on acceptance.
REQ-018 SHIFT -> IDLE on transfer of the last bit when sym_valid is 0.
REQ-019 On transfer of the last bit with sym_valid 1, the block SHALL remain in SHIFT and accept the new symbol.
REQ-020 sym_ready SHALL be 1 in IDLE, and 1 in SHIFT only when the remaining count is 1 and bit_ready is 1.
REQ-021 Latency: the first code bit SHALL be on bit_out with bit_valid 1 in the cycle after acceptance; back-to-back codewords SHALL have no idle cycle between them.
REQ-022 bit_valid SHALL equal (state == SHIFT); busy SHALL equal bit_valid.
REQ-023 While bit_ready is 0, bit_out, the shift register and the counter SHALL hold.
REQ-024 In IDLE, bit_out SHALL be 0.
REQ-025 symbol_in SHALL be ignored when sym_ready is 0; the symbol SHALL be held upstream.

Reset
REQ-026 While rst is 0, the state SHALL be IDLE, the shift register and counter SHALL be 0, bit_out 0, bit_valid 0, busy 0, and sym_ready 0.
REQ-027 An assertion of rst mid-codeword SHALL discard the remaining bits immediately, with no partial-bit completion.
REQ-028 sym_ready SHALL go to 1 in the first cycle after rst deasserts.

Verification
REQ-029 Scenario: accept symbol 1, bit_ready held 1 -> bit_out 0 for exactly 1 cycle with bit_valid 1, then bit_valid 0.
REQ-030 Scenario: accept symbol 3 -> bits 1,1,0 on 3 consecutive cycles; sym_ready 1 during the third bit.
REQ-031 Scenario: accept symbol 20 -> 12 bits 1111111 10100; accept symbol 0 -> 1111111 00000.
REQ-032 Scenario: symbols 2 then 1 presented back-to-back -> bits 1,0,0 on 3 consecutive cycles with bit_valid continuously 1.
REQ-033 Scenario: symbol 4, bit_ready 0 for 3 cycles after the second bit -> bit_out held at 1, then stream completes as 1,1,1,0 with no lost or duplicated bit.
REQ-034 Scenario: rst driven 0 during the 5th bit of symbol 9 -> all outputs 0 asynchronously; after release, symbol 2 encodes cleanly as 1,0.
